displacement_divider: RTL and testbench



---
 rtl/displacement_divider_pkg.sv | 37 +++
 rtl/displacement_divider_if.sv | 32 +++
 rtl/displacement_divider_serial_udiv.sv | 70 +++++++
 rtl/displacement_divider.sv | 163 ++++++++++++++++
 tb/tb_displacement_divider.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/displacement_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : displacement_divider_pkg
//  Description : Shared state encoding, shift default and saturation bounds
//                for the series-elastic displacement divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package displacement_divider_pkg;

    // State encoding of the top-level sequencer
    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_divide = 2'd1;
    localparam logic [1:0] c_st_fix    = 2'd2;
    localparam logic [1:0] c_st_done   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = c_st_idle,
        ST_DIVIDE = c_st_divide,
        ST_FIX    = c_st_fix,
        ST_DONE   = c_st_done
    } state_t;

    // Spring-side encoder counts are scaled down by 2^3 before subtraction
    localparam int ENC1_SHIFT_DEFAULT = 3;

    // Largest two's complement value representable in 'width' bits
    function automatic longint sat_max(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    // Smallest two's complement value representable in 'width' bits
    function automatic longint sat_min(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/displacement_divider_if.sv
`default_nettype none
// ============================================================================
//  Module      : displacement_divider_if
//  Description : Operand/result bundle between the encoder/comms logic and
//                the displacement divider.
//  Revision    : 1.0 - initial release
// ============================================================================
interface displacement_divider_if #(
    parameter int WIDTH = 24
);
    logic                    enable;
    logic signed [WIDTH-1:0] encoder0_position;
    logic signed [WIDTH-1:0] encoder1_position;
    logic signed [WIDTH-1:0] gearBoxRatio;
    logic signed [WIDTH-1:0] displacement;
    logic                    valid;
    logic                    div_zero;
    logic                    busy;

    // Producer of operands / consumer of the result
    modport master (
        output enable, encoder0_position, encoder1_position, gearBoxRatio,
        input  displacement, valid, div_zero, busy
    );

    // The divider itself
    modport slave (
        input  enable, encoder0_position, encoder1_position, gearBoxRatio,
        output displacement, valid, div_zero, busy
    );
endinterface
`default_nettype wire

// File: rtl/displacement_divider_serial_udiv.sv
`default_nettype none
// ============================================================================
//  Module      : serial_udiv
//  Description : Unsigned restoring divider, one quotient bit per clock,
//                MSB first. 'start' loads the operands; 'done' is high during
//                the cycle whose closing edge retires the last quotient bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_udiv #(
    parameter int WIDTH = 24
) (
    input  wire logic             CLK,
    input  wire logic             reset,
    input  wire logic             start,
    input  wire logic [WIDTH-1:0] dividend,
    input  wire logic [WIDTH-1:0] divisor,
    output logic      [WIDTH-1:0] quotient,
    output logic      [WIDTH-1:0] remainder,
    output logic                  done
);
    localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quot;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]   r_div;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_active;

    logic [WIDTH:0]     w_shift;
    logic [WIDTH+1:0]   w_diff;
    logic               w_fits;

    // Trial subtraction of the divisor from the shifted partial remainder
    always_comb begin
        w_shift = {r_rem, r_quot[WIDTH-1]};
        w_diff  = {1'b0, w_shift} - {2'b00, r_div};
        w_fits  = ~w_diff[WIDTH+1];
    end

    // Load on start, then retire one quotient bit per clock
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_rem    <= '0;
            r_quot   <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (start) begin
            r_rem    <= '0;
            r_quot   <= dividend;
            r_div    <= divisor;
            r_cnt    <= c_cnt_w'(WIDTH - 1);
            r_active <= 1'b1;
        end else if (r_active) begin
            r_rem  <= w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_quot <= {r_quot[WIDTH-2:0], w_fits};
            if (r_cnt == '0) begin
                r_active <= 1'b0;
            end else begin
                r_cnt <= r_cnt - c_cnt_w'(1);
            end
        end
    end

    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign done      = r_active && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/displacement_divider.sv
`default_nettype none
// ============================================================================
//  Module      : displacement_divider
//  Description : Multi-cycle signed computation of
//                  encoder0_position / gearBoxRatio - (encoder1_position >>> 3)
//                with truncating division and saturation to WIDTH bits.
//                One result every WIDTH+3 cycles when enable is held high.
//  Revision    : 1.0 - initial release
// ============================================================================
module displacement_divider
    import displacement_divider_pkg::*;
#(
    parameter int WIDTH      = 24,
    parameter int ENC1_SHIFT = ENC1_SHIFT_DEFAULT
) (
    input  wire logic              CLK,
    input  wire logic              reset,
    displacement_divider_if.slave  bus
);
    localparam logic signed [WIDTH:0]   c_max_ext = (WIDTH+1)'(sat_max(WIDTH));
    localparam logic signed [WIDTH:0]   c_min_ext = (WIDTH+1)'(sat_min(WIDTH));
    localparam logic signed [WIDTH-1:0] c_max     = WIDTH'(sat_max(WIDTH));
    localparam logic signed [WIDTH-1:0] c_min     = WIDTH'(sat_min(WIDTH));

    state_t r_state;
    state_t w_state_next;

    logic signed [WIDTH-1:0] r_enc1;
    logic signed [WIDTH-1:0] r_ratio;
    logic                    r_neg;
    logic signed [WIDTH-1:0] r_result;
    logic signed [WIDTH-1:0] r_disp;
    logic                    r_valid;
    logic                    r_div_zero;
    logic                    r_busy;

    logic                    w_capture;
    logic [WIDTH-1:0]        w_enc0_mag;
    logic [WIDTH-1:0]        w_ratio_mag;
    logic [WIDTH-1:0]        w_quot;
    logic [WIDTH-1:0]        w_remainder_unused;
    logic                    w_div_done;

    logic signed [WIDTH:0]   w_q_ext;
    logic signed [WIDTH:0]   w_q_signed;
    logic signed [WIDTH-1:0] w_q_sat;
    logic signed [WIDTH-1:0] w_enc1_sh;
    logic signed [WIDTH:0]   w_diff;
    logic signed [WIDTH-1:0] w_result;

    assign w_capture = (r_state == ST_IDLE) && bus.enable;

    // Magnitudes of the live operands; the most negative value maps to 2^(WIDTH-1)
    always_comb begin
        w_enc0_mag  = bus.encoder0_position;
        w_ratio_mag = bus.gearBoxRatio;
        if (bus.encoder0_position[WIDTH-1]) begin
            w_enc0_mag = '0 - bus.encoder0_position;
        end
        if (bus.gearBoxRatio[WIDTH-1]) begin
            w_ratio_mag = '0 - bus.gearBoxRatio;
        end
    end

    serial_udiv #(
        .WIDTH (WIDTH)
    ) u_serial_udiv (
        .CLK       (CLK),
        .reset     (reset),
        .start     (w_capture),
        .dividend  (w_enc0_mag),
        .divisor   (w_ratio_mag),
        .quotient  (w_quot),
        .remainder (w_remainder_unused),
        .done      (w_div_done)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state sequencing: IDLE -> DIVIDE (WIDTH cycles) -> FIX -> DONE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (bus.enable) w_state_next = ST_DIVIDE;
            ST_DIVIDE: if (w_div_done) w_state_next = ST_FIX;
            ST_FIX:    w_state_next = ST_DONE;
            ST_DONE:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Sign restore, saturation and spring-offset subtraction
    always_comb begin
        w_q_ext    = signed'({1'b0, w_quot});
        w_q_signed = r_neg ? -w_q_ext : w_q_ext;
        if (w_q_signed > c_max_ext) begin
            w_q_sat = c_max;
        end else if (w_q_signed < c_min_ext) begin
            w_q_sat = c_min;
        end else begin
            w_q_sat = w_q_signed[WIDTH-1:0];
        end

        w_enc1_sh = r_enc1 >>> ENC1_SHIFT;
        w_diff    = signed'({w_q_sat[WIDTH-1], w_q_sat} - {w_enc1_sh[WIDTH-1], w_enc1_sh});
        if (w_diff > c_max_ext) begin
            w_result = c_max;
        end else if (w_diff < c_min_ext) begin
            w_result = c_min;
        end else begin
            w_result = w_diff[WIDTH-1:0];
        end
    end

    // Operand capture, result staging and output registers
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_enc1     <= '0;
            r_ratio    <= '0;
            r_neg      <= 1'b0;
            r_result   <= '0;
            r_disp     <= '0;
            r_valid    <= 1'b0;
            r_div_zero <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            if (w_capture) begin
                r_enc1  <= bus.encoder1_position;
                r_ratio <= bus.gearBoxRatio;
                r_neg   <= bus.encoder0_position[WIDTH-1] ^ bus.gearBoxRatio[WIDTH-1];
            end
            if (r_state == ST_FIX) begin
                r_result <= w_result;
            end
            // A zero divisor keeps the previous displacement and flags it instead
            if (r_state == ST_DONE) begin
                if (r_ratio != '0) begin
                    r_disp     <= r_result;
                    r_div_zero <= 1'b0;
                end else begin
                    r_div_zero <= 1'b1;
                end
            end
            r_valid <= (r_state == ST_DONE);
            // Busy spans the capture edge through the edge after the result update
            r_busy  <= (w_state_next != ST_IDLE) || (r_state == ST_DONE);
        end
    end

    assign bus.displacement = r_disp;
    assign bus.valid        = r_valid;
    assign bus.div_zero     = r_div_zero;
    assign bus.busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_displacement_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_displacement_divider
//  Description : Self-checking bench for displacement_divider: directed cases,
//                randomized operands, continuous mode and mid-run reset,
//                checked against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_displacement_divider;
    localparam int     W       = 24;
    localparam longint MAX_VAL = 8388607;
    localparam longint MIN_VAL = -8388608;

    logic CLK   = 1'b0;
    logic reset = 1'b1;

    always #5 CLK = ~CLK;

    displacement_divider_if #(.WIDTH(W)) bus ();

    displacement_divider #(
        .WIDTH      (W),
        .ENC1_SHIFT (3)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    int     n_vec = 0;
    int     n_err = 0;
    longint m_disp = 0;
    longint m_dz   = 0;
    longint q_disp[$];
    longint q_dz[$];

    task automatic check_val(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint clamp(input longint v);
        if (v > MAX_VAL) return MAX_VAL;
        if (v < MIN_VAL) return MIN_VAL;
        return v;
    endfunction

    // Division by 8 rounded toward minus infinity
    function automatic longint floor_div8(input longint v);
        return (v - (((v % 8) + 8) % 8)) / 8;
    endfunction

    // Reference: truncating divide, saturate, subtract scaled spring count, saturate
    function automatic void model_apply(input longint e0, input longint r, input longint e1);
        if (r == 0) begin
            m_dz = 1;
        end else begin
            m_disp = clamp(clamp(e0 / r) - floor_div8(e1));
            m_dz   = 0;
        end
    endfunction

    function automatic logic signed [W-1:0] rand_val();
        logic signed [W-1:0] v;
        v = W'($urandom);
        return v;
    endfunction

    function automatic logic signed [W-1:0] rand_ratio();
        int unsigned sel;
        logic signed [W-1:0] v;
        sel = $urandom_range(0, 9);
        if (sel == 0)      v = '0;
        else if (sel <= 2) v = rand_val();
        else begin
            v = W'($urandom_range(1, 300));
            if ($urandom_range(0, 1) == 1) v = -v;
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_inputs(input longint e0, input longint r, input longint e1);
        bus.encoder0_position = W'(e0);
        bus.gearBoxRatio      = W'(r);
        bus.encoder1_position = W'(e1);
    endtask

    // One computation from IDLE, with inputs disturbed after capture
    task automatic do_op(input longint e0, input longint r, input longint e1, input string tag);
        int n;
        set_inputs(e0, r, e1);
        bus.enable = 1'b1;
        tick();
        bus.enable = 1'b0;
        set_inputs(rand_val(), rand_val(), rand_val());
        check_val({tag, "_busy_k"}, bus.busy, 1);
        n = 0;
        while (bus.valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check_val({tag, "_latency"}, n, 26);
        model_apply(e0, r, e1);
        check_val({tag, "_disp"}, bus.displacement, m_disp);
        check_val({tag, "_div_zero"}, bus.div_zero, m_dz);
        tick();
        check_val({tag, "_valid_1cyc"}, bus.valid, 0);
        check_val({tag, "_busy_end"}, bus.busy, 0);
    endtask

    initial begin
        int seen;
        longint e0, r, e1;
        bus.enable = 1'b0;
        set_inputs(0, 0, 0);
        repeat (3) tick();
        check_val("rst_disp", bus.displacement, 0);
        check_val("rst_valid", bus.valid, 0);
        check_val("rst_div_zero", bus.div_zero, 0);
        check_val("rst_busy", bus.busy, 0);
        reset = 1'b0;
        tick();

        do_op(1000, 10, 80, "basic");
        do_op(-1001, 10, -9, "signs");
        do_op(1000, 10, 80, "pre_div0");
        do_op(5000, 0, 3, "div0");
        do_op(70, 7, 0, "after_div0");
        do_op(-8388608, -1, 0, "sat_q");
        do_op(8388607, 1, -8388608, "sat_sub");

        // Idle with enable low holds the result
        seen = 0;
        repeat (5) begin
            tick();
            if (bus.valid === 1'b1) seen = 1;
        end
        check_val("idle_no_valid", seen, 0);
        check_val("idle_hold", bus.displacement, m_disp);
        check_val("idle_busy", bus.busy, 0);

        for (int i = 0; i < 25; i++) begin
            do_op(rand_val(), rand_ratio(), rand_val(), "rand");
        end

        // Continuous mode: enable held, inputs change every 5 cycles
        bus.enable = 1'b1;
        for (int c = 0; c < 108; c++) begin
            if (c % 5 == 0) set_inputs(rand_val(), rand_ratio(), rand_val());
            if (c % 27 == 0) begin
                e0 = bus.encoder0_position;
                r  = bus.gearBoxRatio;
                e1 = bus.encoder1_position;
                model_apply(e0, r, e1);
                q_disp.push_back(m_disp);
                q_dz.push_back(m_dz);
            end
            tick();
            if (c % 27 == 26) begin
                check_val("cont_valid", bus.valid, 1);
                check_val("cont_disp", bus.displacement, q_disp.pop_front());
                check_val("cont_div_zero", bus.div_zero, q_dz.pop_front());
            end else begin
                check_val("cont_valid_low", bus.valid, 0);
            end
        end
        bus.enable = 1'b0;
        tick();
        check_val("cont_busy_end", bus.busy, 0);

        // Reset during the 10th DIVIDE cycle
        do_op(1000, 10, 80, "pre_rst");
        set_inputs(123456, 3, 16);
        bus.enable = 1'b1;
        tick();
        bus.enable = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_disp = 0;
        m_dz   = 0;
        check_val("midrst_disp", bus.displacement, 0);
        check_val("midrst_busy", bus.busy, 0);
        check_val("midrst_valid", bus.valid, 0);
        check_val("midrst_div_zero", bus.div_zero, 0);
        seen = 0;
        repeat (30) begin
            tick();
            if (bus.valid === 1'b1) seen = 1;
        end
        check_val("midrst_no_valid", seen, 0);
        do_op(-50000, 7, 1000, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit exceeded");
    end

endmodule
`default_nettype wire
